// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, 3-sample mid-bit majority vote, VALID/ACK hold.
// Define UART_RX_PARITY_EN to add a parity bit after the data bits and the PAR_ERR port.
module uart_rx_param #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8,
   parameter int STOP_BITS    = 1,
   parameter int PARITY_ODD   = 0
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 RX,
   input  logic                 ACK,
   output logic [DATA_BITS-1:0] DATA,
   output logic                 VALID,
   output logic                 BUSY,
   output logic                 FRAME_ERR,
   output logic                 OVERRUN
`ifdef UART_RX_PARITY_EN
   ,
   output logic                 PAR_ERR
`endif
);

   localparam int H     = CLKS_PER_BIT / 2;
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W = $clog2(DATA_BITS);

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] SMP_A     = CNT_W'(H - 1);
   localparam logic [CNT_W-1:0] SMP_B     = CNT_W'(H);
   localparam logic [CNT_W-1:0] SMP_V     = CNT_W'(H + 1);
   localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_WAIT_HIGH
   } state_t;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   logic                 sync1_q, sync2_q;
   logic                 rxs;
   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [1:0]           samp_q, samp_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 ferr_q, ferr_d;
   logic                 ovr_q, ovr_d;
   logic                 commit;
   logic                 at_vote;
   logic                 vote;
`ifdef UART_RX_PARITY_EN
   logic                 par_q, par_d;
   logic                 perr_q, perr_d;
`endif

   assign rxs     = sync2_q;
   assign at_vote = (cnt_q == SMP_V);
   // Two earlier samples are held; the third is the live synchronised line at the vote point.
   assign vote    = maj3(samp_q[0], samp_q[1], rxs);

   always_comb begin
      state_d = state_q;
      cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
      bit_d   = bit_q;
      samp_d  = samp_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = valid_q & ~ACK;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;
      commit  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_d   = par_q;
      perr_d  = 1'b0;
`endif

      if (cnt_q == SMP_A) samp_d[0] = rxs;
      if (cnt_q == SMP_B) samp_d[1] = rxs;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            bit_d = '0;
            if (!rxs) state_d = S_START;
         end
         S_START: begin
            if (at_vote) state_d = vote ? S_IDLE : S_DATA;
         end
         S_DATA: begin
            if (at_vote) begin
               shift_d = {vote, shift_q[DATA_BITS-1:1]};
               if (bit_q == DATA_LAST) begin
                  bit_d = '0;
`ifdef UART_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (at_vote) begin
               par_d   = vote;
               state_d = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (at_vote) begin
               if (!vote) begin
                  ferr_d  = 1'b1;
                  state_d = S_WAIT_HIGH;
               end else if (bit_q == STOP_LAST) begin
                  // Leave mid-stop so the next start edge is caught with half a bit of margin.
                  state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                  if (par_q != (^shift_q ^ (PARITY_ODD != 0))) perr_d = 1'b1;
                  else                                         commit = 1'b1;
`else
                  commit = 1'b1;
`endif
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end
         end
         S_WAIT_HIGH: begin
            if (rxs) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // A same-cycle ACK consumes the old word, so the new one is not an overrun.
      if (commit) begin
         data_d  = shift_q;
         valid_d = 1'b1;
         ovr_d   = valid_q & ~ACK;
      end
   end

   // Control and output registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q  <= 1'b0;
`endif
      end else begin
         sync1_q <= RX;
         sync2_q <= sync1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
         perr_q  <= perr_d;
`endif
      end
   end

   // Datapath registers: always fully rewritten before use within a frame.
   always_ff @(posedge CLK) begin
      samp_q  <= samp_d;
      shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
`endif
   end

   assign DATA      = data_q;
   assign VALID     = valid_q;
   assign BUSY      = (state_q != S_IDLE);
   assign FRAME_ERR = ferr_q;
   assign OVERRUN   = ovr_q;
`ifdef UART_RX_PARITY_EN
   assign PAR_ERR   = perr_q;
`endif

endmodule
